// File: rtl/vga_timing_gen.sv
// vga_timing_gen
//   Parametrised VGA raster timing generator. A prescaler divides the system
//   clock down to the pixel rate. On each pixel tick the generator advances the
//   (x, y) raster position and produces the sync, display-enable and strobe
//   outputs for the pixel now shown on x/y.
//
// Ports
//   clk         system clock; all state updates on the falling edge
//   rst         asynchronous reset, active low
//   en          run enable; when low, all counters and levels freeze
//   hs, vs      horizontal / vertical sync, active level HS_POL / VS_POL
//   de          display enable, high inside the visible area
//   x, y        current pixel column / line
//   pix_tick    one-clk strobe after each pixel advance
//   line_start  one-clk strobe when the raster enters x=0
//   frame_start one-clk strobe when the raster enters (0,0)
module vga_timing_gen #(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33,
  parameter logic        HS_POL   = 1'b0,
  parameter logic        VS_POL   = 1'b0,
  parameter int unsigned CLK_DIV  = 2,
  parameter int unsigned CW       = 11
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  output logic          hs,
  output logic          vs,
  output logic          de,
  output logic [CW-1:0] x,
  output logic [CW-1:0] y,
  output logic          pix_tick,
  output logic          frame_start,
  output logic          line_start
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned DW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [CW-1:0] H_LAST   = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST   = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] H_ACT    = CW'(H_ACTIVE);
  localparam logic [CW-1:0] V_ACT    = CW'(V_ACTIVE);
  // Inclusive sync bounds so a zero back porch cannot overflow CW bits.
  localparam logic [CW-1:0] HS_FIRST = CW'(H_ACTIVE + H_FP);
  localparam logic [CW-1:0] HS_LAST  = CW'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [CW-1:0] VS_FIRST = CW'(V_ACTIVE + V_FP);
  localparam logic [CW-1:0] VS_LAST  = CW'(V_ACTIVE + V_FP + V_SYNC - 1);

  logic [DW-1:0] div_q, div_d;
  logic [CW-1:0] x_q, x_d;
  logic [CW-1:0] y_q, y_d;
  logic          hs_q, hs_d;
  logic          vs_q, vs_d;
  logic          de_q, de_d;
  logic          pt_q, ls_q, fs_q;
  logic          tick;

  assign tick = en && (div_q == DIV_LAST);

  always_comb begin
    div_d = div_q;
    x_d   = x_q;
    y_d   = y_q;
    if (en) begin
      div_d = tick ? '0 : div_q + DW'(1);
    end
    if (tick) begin
      x_d = (x_q == H_LAST) ? '0 : x_q + CW'(1);
      if (x_q == H_LAST) begin
        y_d = (y_q == V_LAST) ? '0 : y_q + CW'(1);
      end
    end
  end

  // Levels are derived from the next position so they register together
  // with x/y and always describe the pixel currently presented.
  always_comb begin
    hs_d = ((x_d >= HS_FIRST) && (x_d <= HS_LAST)) ? HS_POL : ~HS_POL;
    vs_d = ((y_d >= VS_FIRST) && (y_d <= VS_LAST)) ? VS_POL : ~VS_POL;
    de_d = (x_d < H_ACT) && (y_d < V_ACT);
  end

  always_ff @(negedge clk or negedge rst) begin
    if (!rst) begin
      div_q <= '0;
      x_q   <= H_LAST;
      y_q   <= V_LAST;
      hs_q  <= ~HS_POL;
      vs_q  <= ~VS_POL;
      de_q  <= 1'b0;
      pt_q  <= 1'b0;
      ls_q  <= 1'b0;
      fs_q  <= 1'b0;
    end else begin
      div_q <= div_d;
      x_q   <= x_d;
      y_q   <= y_d;
      hs_q  <= hs_d;
      vs_q  <= vs_d;
      de_q  <= de_d;
      pt_q  <= tick;
      ls_q  <= tick && (x_d == '0);
      fs_q  <= tick && (x_d == '0) && (y_d == '0);
    end
  end

  assign x           = x_q;
  assign y           = y_q;
  assign hs          = hs_q;
  assign vs          = vs_q;
  assign de          = de_q;
  assign pix_tick    = pt_q;
  assign line_start  = ls_q;
  assign frame_start = fs_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: default 640x480 mode, a tiny mode (CLK_DIV=3)
// small enough to cover whole frames, and an 800x600 positive-sync mode with
// CLK_DIV=1. Vectors give expected outputs n falling edges after reset release.
module tb_vga_timing_gen;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic en_def = 1'b1, en_sml = 1'b1, en_var = 1'b1;

  logic        d_hs, d_vs, d_de, d_pt, d_fs, d_ls;
  logic [10:0] d_x, d_y;
  logic        s_hs, s_vs, s_de, s_pt, s_fs, s_ls;
  logic [4:0]  s_x, s_y;
  logic        v_hs, v_vs, v_de, v_pt, v_fs, v_ls;
  logic [10:0] v_x, v_y;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  vga_timing_gen u_def (
    .clk(clk), .rst(rst), .en(en_def), .hs(d_hs), .vs(d_vs), .de(d_de),
    .x(d_x), .y(d_y), .pix_tick(d_pt), .frame_start(d_fs), .line_start(d_ls)
  );

  vga_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(6), .V_FP(2), .V_SYNC(2), .V_BP(3),
    .CLK_DIV(3), .CW(5)
  ) u_sml (
    .clk(clk), .rst(rst), .en(en_sml), .hs(s_hs), .vs(s_vs), .de(s_de),
    .x(s_x), .y(s_y), .pix_tick(s_pt), .frame_start(s_fs), .line_start(s_ls)
  );

  vga_timing_gen #(
    .H_ACTIVE(800), .H_FP(40), .H_SYNC(128), .H_BP(88),
    .V_ACTIVE(600), .V_FP(1), .V_SYNC(4), .V_BP(23),
    .HS_POL(1'b1), .VS_POL(1'b1), .CLK_DIV(1), .CW(11)
  ) u_var (
    .clk(clk), .rst(rst), .en(en_var), .hs(v_hs), .vs(v_vs), .de(v_de),
    .x(v_x), .y(v_y), .pix_tick(v_pt), .frame_start(v_fs), .line_start(v_ls)
  );

  typedef struct {
    int dut;  // 0 default, 1 small, 2 800x600
    int n;
    int x, y, hs, vs, de, pt, ls, fs;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(input int dut, input int n, input int x, input int y,
                              input int hs, input int vs, input int de,
                              input int pt, input int ls, input int fs);
    vec_t v;
    v.dut = dut; v.n = n; v.x = x; v.y = y; v.hs = hs; v.vs = vs; v.de = de;
    v.pt = pt; v.ls = ls; v.fs = fs;
    tbl.push_back(v);
  endfunction

  task automatic cmp(input string nm, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic check_state(input string tag, input int d, input int x, input int y,
                             input int hs, input int vs, input int de,
                             input int pt, input int ls, input int fs);
    int ax, ay, ahs, avs, ade, apt, als, afs;
    case (d)
      0: begin ax = d_x; ay = d_y; ahs = d_hs; avs = d_vs; ade = d_de;
               apt = d_pt; als = d_ls; afs = d_fs; end
      1: begin ax = s_x; ay = s_y; ahs = s_hs; avs = s_vs; ade = s_de;
               apt = s_pt; als = s_ls; afs = s_fs; end
      default: begin ax = v_x; ay = v_y; ahs = v_hs; avs = v_vs; ade = v_de;
               apt = v_pt; als = v_ls; afs = v_fs; end
    endcase
    cmp({tag, ".x"}, ax, x);
    cmp({tag, ".y"}, ay, y);
    cmp({tag, ".hs"}, ahs, hs);
    cmp({tag, ".vs"}, avs, vs);
    cmp({tag, ".de"}, ade, de);
    cmp({tag, ".pix_tick"}, apt, pt);
    cmp({tag, ".line_start"}, als, ls);
    cmp({tag, ".frame_start"}, afs, fs);
  endtask

  // Caller releases reset #1 after a rising edge; n=0 is checked right away,
  // then once per clock, #1 after each rising edge (mid-way between falling edges).
  task automatic run_table(input int maxn);
    for (int n = 0; n <= maxn; n++) begin
      if (n > 0) begin
        @(posedge clk);
        #1;
      end
      foreach (tbl[i]) begin
        if (tbl[i].n == n)
          check_state($sformatf("d%0d_n%0d", tbl[i].dut, n), tbl[i].dut, tbl[i].x,
                      tbl[i].y, tbl[i].hs, tbl[i].vs, tbl[i].de, tbl[i].pt,
                      tbl[i].ls, tbl[i].fs);
      end
      if (n > 0) cmp($sformatf("var_pt_every_clk_n%0d", n), int'(v_pt), 1);
    end
  endtask

  initial begin
    int  x0, y0, h0;
    bit  found;

    //   dut  n     x     y    hs vs de pt ls fs
    // default mode, CLK_DIV=2: pixel p = n/2-1 after n falling edges
    add(0,    0,  799,  524,  1, 1, 0, 0, 0, 0);
    add(0,    1,  799,  524,  1, 1, 0, 0, 0, 0);
    add(0,    2,    0,    0,  1, 1, 1, 1, 1, 1);
    add(0,    3,    0,    0,  1, 1, 1, 0, 0, 0);
    add(0,    4,    1,    0,  1, 1, 1, 1, 0, 0);
    add(0, 1280,  639,    0,  1, 1, 1, 1, 0, 0);
    add(0, 1281,  639,    0,  1, 1, 1, 0, 0, 0);
    add(0, 1282,  640,    0,  1, 1, 0, 1, 0, 0);
    add(0, 1313,  655,    0,  1, 1, 0, 0, 0, 0);
    add(0, 1314,  656,    0,  0, 1, 0, 1, 0, 0);
    add(0, 1505,  751,    0,  0, 1, 0, 0, 0, 0);
    add(0, 1506,  752,    0,  1, 1, 0, 1, 0, 0);
    add(0, 1600,  799,    0,  1, 1, 0, 1, 0, 0);
    add(0, 1601,  799,    0,  1, 1, 0, 0, 0, 0);
    add(0, 1602,    0,    1,  1, 1, 1, 1, 1, 0);
    add(0, 3202,    0,    2,  1, 1, 1, 1, 1, 0);
    // small mode 16x13, CLK_DIV=3: hs low x=10..12, vs low y=8..9
    add(1,    0,   15,   12,  1, 1, 0, 0, 0, 0);
    add(1,    3,    0,    0,  1, 1, 1, 1, 1, 1);
    add(1,    4,    0,    0,  1, 1, 1, 0, 0, 0);
    add(1,   33,   10,    0,  0, 1, 0, 1, 0, 0);
    add(1,   39,   12,    0,  0, 1, 0, 1, 0, 0);
    add(1,   42,   13,    0,  1, 1, 0, 1, 0, 0);
    add(1,  291,    0,    6,  1, 1, 0, 1, 1, 0);
    add(1,  386,   15,    7,  1, 1, 0, 0, 0, 0);
    add(1,  387,    0,    8,  1, 0, 0, 1, 1, 0);
    add(1,  434,   15,    8,  1, 0, 0, 0, 0, 0);
    add(1,  435,    0,    9,  1, 0, 0, 1, 1, 0);
    add(1,  483,    0,   10,  1, 1, 0, 1, 1, 0);
    add(1,  626,   15,   12,  1, 1, 0, 0, 0, 0);
    add(1,  627,    0,    0,  1, 1, 1, 1, 1, 1);
    // 800x600 mode, CLK_DIV=1, positive sync: hs high x=840..967
    add(2,    0, 1055,  627,  0, 0, 0, 0, 0, 0);
    add(2,    1,    0,    0,  0, 0, 1, 1, 1, 1);
    add(2,    2,    1,    0,  0, 0, 1, 1, 0, 0);
    add(2,  801,  800,    0,  0, 0, 0, 1, 0, 0);
    add(2,  840,  839,    0,  0, 0, 0, 1, 0, 0);
    add(2,  841,  840,    0,  1, 0, 0, 1, 0, 0);
    add(2,  968,  967,    0,  1, 0, 0, 1, 0, 0);
    add(2,  969,  968,    0,  0, 0, 0, 1, 0, 0);
    add(2, 1056, 1055,    0,  0, 0, 0, 1, 0, 0);
    add(2, 1057,    0,    1,  0, 0, 1, 1, 1, 0);

    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    run_table(3300);

    // Freeze the default generator for 37 clocks right after a pixel tick.
    found = 0;
    for (int i = 0; i < 10 && !found; i++) begin
      @(posedge clk);
      #1;
      if (d_pt) found = 1;
    end
    cmp("en_find_tick", int'(found), 1);
    x0 = d_x; y0 = d_y; h0 = d_hs;
    en_def = 1'b0;
    for (int i = 0; i < 37; i++) begin
      @(posedge clk);
      #1;
      cmp($sformatf("frz%0d.x", i), int'(d_x), x0);
      cmp($sformatf("frz%0d.y", i), int'(d_y), y0);
      cmp($sformatf("frz%0d.hs", i), int'(d_hs), h0);
      cmp($sformatf("frz%0d.pix_tick", i), int'(d_pt), 0);
      cmp($sformatf("frz%0d.line_start", i), int'(d_ls), 0);
    end
    en_def = 1'b1;
    @(posedge clk);
    #1;
    cmp("resume0.pix_tick", int'(d_pt), 0);
    cmp("resume0.x", int'(d_x), x0);
    for (int k = 1; k <= 10; k++) begin
      @(posedge clk);
      #1;
      cmp($sformatf("resume%0d.pix_tick", k), int'(d_pt), 1);
      cmp($sformatf("resume%0d.x", k), int'(d_x), x0 + k);
      @(posedge clk);
      #1;
      cmp($sformatf("resume%0d.gap", k), int'(d_pt), 0);
    end

    // Asynchronous reset while hs is asserted at x=700.
    found = 0;
    for (int i = 0; i < 4000 && !found; i++) begin
      @(posedge clk);
      #1;
      if (d_x == 11'd700) found = 1;
    end
    cmp("rst_find_x700", int'(found), 1);
    cmp("rst_pre.hs", int'(d_hs), 0);
    #2 rst = 1'b0;
    #1;
    check_state("rst_async", 0, 799, 524, 1, 1, 0, 0, 0, 0);
    @(negedge clk);
    #1;
    check_state("rst_held", 0, 799, 524, 1, 1, 0, 0, 0, 0);
    @(posedge clk);
    #1 rst = 1'b1;
    run_table(10);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Parametrised VGA raster timing generator that drives the display path. It produces horizontal/vertical sync, the pixel coordinates, a display-enable flag and per-pixel/per-frame strobes from the system clock. All horizontal/vertical timings, sync polarities and the system-to-pixel clock ratio are set by parameters, so other modes need no RTL change. The pixel fetch and colour logic consume `x`, `y`, `de` and `pix_tick` directly.

## Interface
- `H_ACTIVE`, 640: visible pixels per line.
- `H_FP`, 16: horizontal front porch, in pixels.
- `H_SYNC`, 96: horizontal sync width, in pixels.
- `H_BP`, 48: horizontal back porch, in pixels.
- `V_ACTIVE`, 480: visible lines per frame.
- `V_FP`, 10: vertical front porch, in lines.
- `V_SYNC`, 2: vertical sync width, in lines.
- `V_BP`, 33: vertical back porch, in lines.
- `HS_POL`, 0: active level of `hs`.
- `VS_POL`, 0: active level of `vs`.
- `CLK_DIV`, 2: system clocks per pixel. Must be ≥1.
- `CW`, 11: counter width. Must satisfy 2^CW ≥ max(H_TOTAL, V_TOTAL).
- `clk` in 1: system clock. All state updates on the falling edge.
- `rst` in 1: asynchronous, active-low reset.
- `en` in 1: run enable. When low, the generator freezes.
- `hs` out 1: horizontal sync.
- `vs` out 1: vertical sync.
- `de` out 1: display enable; high inside the active area.
- `x` out CW: pixel column.
- `y` out CW: line number.
- `pix_tick` out 1: one-clk strobe marking each pixel advance.
- `frame_start` out 1: one-clk strobe when the raster enters (0,0).
- `line_start` out 1: one-clk strobe when the raster enters x=0 on any line.

## Operation
- Derived totals:
  - H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP.
  - V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP.
- Prescaler:
  - `div_cnt` counts 0..CLK_DIV-1 on each clk where `en`=1.
  - A tick occurs on the edge where `div_cnt`=CLK_DIV-1; `div_cnt` returns to 0 on that edge.
  - With CLK_DIV=1, every enabled edge is a tick.
- On a tick:
  - x ← (x==H_TOTAL-1) ? 0 : x+1.
  - If x==H_TOTAL-1, then y ← (y==V_TOTAL-1) ? 0 : y+1.
- All outputs are registered and computed from the next (x,y), so they always describe the pixel currently on `x`/`y`:
  - `hs` = HS_POL when H_ACTIVE+H_FP ≤ x < H_ACTIVE+H_FP+H_SYNC, else ~HS_POL.
  - `vs` = VS_POL when V_ACTIVE+V_FP ≤ y < V_ACTIVE+V_FP+V_SYNC, else ~VS_POL.
  - `de` = (x<H_ACTIVE)&&(y<V_ACTIVE).
- Strobes:
  - `pix_tick` is high for exactly the clk cycle following each tick edge.
  - `line_start` is high in that same cycle when the new x=0.
  - `frame_start` is high in that same cycle when the new (x,y)=(0,0).
  - All strobes are low in every other cycle, including when CLK_DIV>1.
- `en`=0:
  - `div_cnt`, x, y, `hs`, `vs` and `de` hold their values.
  - All strobes go low on the next edge.
  - Resuming continues from the held `div_cnt`; no count is lost or duplicated.
- Reset (asynchronous, any time, including mid-line or mid-sync):
  - `div_cnt`=0, x=H_TOTAL-1, y=V_TOTAL-1.
  - `hs`=~HS_POL, `vs`=~VS_POL, `de`=0.
  - `pix_tick`=`line_start`=`frame_start`=0.
  - Counters park on the last pixel of the frame, so the first tick after release produces (0,0) with `frame_start`.

## Timing
- First tick after `rst` rises (with `en`=1) lands on the CLK_DIV-th falling edge. On that edge the outputs become x=0, y=0, `de`=1, `frame_start`=`line_start`=`pix_tick`=1.
- Pixel period = CLK_DIV clk cycles.
- Line period = H_TOTAL·CLK_DIV clk cycles.
- Frame period = H_TOTAL·V_TOTAL·CLK_DIV clk cycles.
- Output latency: zero relative to x/y. `hs`, `vs` and `de` change on the same edge as the x/y value they describe.
- Wrap-around of x and y at the same tick: both wrap, and `frame_start` asserts.
- `vs` transitions coincide with x=0 of the first/last sync line, i.e. on a `line_start` edge.

## Test plan
- Defaults, `en`=1, release reset:
  - First `pix_tick`/`frame_start` on the 2nd falling edge, with x=0, y=0, `de`=1, `hs`=`vs`=1.
  - Next `frame_start` exactly 840000 clks later.
- Defaults, horizontal timing on any line:
  - `hs`=0 for x=656..751 (96 pixels = 192 clks).
  - `de` falls when x goes 639→640.
  - `line_start` every 1600 clks.
- Defaults, vertical timing:
  - `vs`=0 for y=490..491 (1600·2 = 3200 clks), asserting on the edge where x=0, y=490.
  - `de`=0 for all of y=480..524.
- `en` toggling:
  - Hold `en`=0 for 37 clks mid-line; x/y/`hs` stay frozen and strobes stay low.
  - After `en` returns, `pix_tick` spacing resumes at 2 clks with no skipped x value.
- Reset during `hs` low (x=700):
  - Outputs go immediately to x=799, y=524, `hs`=1, `vs`=1, `de`=0, strobes 0, independent of clk.
  - Restart behaves as in the first scenario.
- Parameter variant: CLK_DIV=1, HS_POL=VS_POL=1, 800×600 timing (40/128/88, 1/4/23):
  - `pix_tick` high every clk.
  - `hs`=1 for x=840..967.
  - `vs`=1 for y=601..604.
  - Frame = 1056·628 clks.
